// File: rtl/oc8051_int_sched.sv
`default_nettype none
// ============================================================================
//  Module   : oc8051_int_sched
//  Brief    : Interrupt scheduler for the instruction selector. Applies
//             IE/IP enable and two-level priority, issues one LCALL request,
//             then tracks the in-service level until RETI.
//             Optional TF2 source enabled by macro OC8051_INT_TF2_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module oc8051_int_sched #(
    parameter int unsigned ACK_TIMEOUT  = 15,
    parameter int unsigned RETI_HOLDOFF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ie,
    input  logic [7:0] ip,
    input  logic       src_ie0,
    input  logic       src_tf0,
    input  logic       src_ie1,
    input  logic       src_tf1,
    input  logic       src_ser,
    input  logic       src_tf2,
    input  logic       reti,
    input  logic       ack,
    output logic       int_o,
    output logic [7:0] int_v,
    output logic       clr_ie0,
    output logic       clr_tf0,
    output logic       clr_ie1,
    output logic       clr_tf1,
    output logic       isr_hi,
    output logic       isr_lo
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    localparam int          c_ho_w     = (RETI_HOLDOFF < 2) ? 1 : $clog2(RETI_HOLDOFF + 1);
    localparam logic [c_ho_w-1:0] c_ho_load = c_ho_w'(RETI_HOLDOFF);
    localparam logic [3:0]  c_tmo_load = 4'(ACK_TIMEOUT);
    localparam logic        c_tmo_en   = (ACK_TIMEOUT != 0);

    logic [1:0]        r_state, w_state_nx;
    logic              r_int, w_int_nx;
    logic [7:0]        r_vec, w_vec_nx;
    logic              r_lvl, w_lvl_nx;
    logic [2:0]        r_id, w_id_nx;
    logic [3:0]        r_clr, w_clr_nx;
    logic [3:0]        r_tmo, w_tmo_nx;
    logic [c_ho_w-1:0] r_ho, w_ho_nx;
    logic              r_isr_hi, w_isr_hi_nx;
    logic              r_isr_lo, w_isr_lo_nx;

    logic              w_src_tf2;
    logic              w_unused;
    logic [5:0]        w_src, w_pend, w_elig, w_elig_hi, w_elig_lo, w_win_set;
    logic              w_win_hi, w_hit;
    logic [2:0]        w_id;

`ifdef OC8051_INT_TF2_EN
    assign w_src_tf2 = src_tf2;
    assign w_unused  = ^{ip[7:6], ie[6]};
`else
    assign w_src_tf2 = 1'b0;
    assign w_unused  = ^{ip[7:6], ie[6], src_tf2};
`endif

    assign w_src  = {w_src_tf2, src_ser, src_tf1, src_ie1, src_tf0, src_ie0};
    assign w_pend = w_src & ie[5:0] & {6{ie[7]}};

    // A high-level service blocks everything; a low-level one admits only high.
    assign w_elig    = r_isr_hi ? 6'b0 : (r_isr_lo ? (w_pend & ip[5:0]) : w_pend);
    assign w_elig_hi = w_elig & ip[5:0];
    assign w_elig_lo = w_elig & ~ip[5:0];
    assign w_win_hi  = |w_elig_hi;
    assign w_win_set = w_win_hi ? w_elig_hi : w_elig_lo;

    // Lowest index wins within a level (IE0 first).
    always_comb begin
        w_hit = 1'b0;
        w_id  = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (w_win_set[i]) begin
                w_hit = 1'b1;
                w_id  = 3'(i);
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_int_nx    = 1'b0;
        w_vec_nx    = r_vec;
        w_lvl_nx    = r_lvl;
        w_id_nx     = r_id;
        w_clr_nx    = 4'b0;
        w_tmo_nx    = r_tmo;
        w_ho_nx     = (r_ho != '0) ? r_ho - 1'b1 : r_ho;
        w_isr_hi_nx = r_isr_hi;
        w_isr_lo_nx = r_isr_lo;

        // RETI clear is applied before any ACK set in the same cycle.
        if (reti) begin
            w_ho_nx = c_ho_load;
            if (r_isr_hi) w_isr_hi_nx = 1'b0;
            else          w_isr_lo_nx = 1'b0;
        end

        case (r_state)
            c_st_idle: begin
                if (w_hit && (r_ho == '0)) begin
                    w_state_nx = c_st_req;
                    w_int_nx   = 1'b1;
                    w_vec_nx   = 8'h03 + {2'b00, w_id, 3'b000};
                    w_lvl_nx   = w_win_hi;
                    w_id_nx    = w_id;
                end
            end
            c_st_req: begin
                w_state_nx = c_st_wait;
                w_tmo_nx   = c_tmo_load;
            end
            c_st_wait: begin
                if (ack) begin
                    if (r_lvl) w_isr_hi_nx = 1'b1;
                    else       w_isr_lo_nx = 1'b1;
                    if (!r_id[2]) w_clr_nx[r_id[1:0]] = 1'b1;
                    w_state_nx = c_st_idle;
                end else if (r_tmo == 4'd0) begin
                    if (c_tmo_en) w_state_nx = c_st_idle;
                end else begin
                    w_tmo_nx = r_tmo - 4'd1;
                end
            end
            default: w_state_nx = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_int    <= 1'b0;
            r_vec    <= 8'h00;
            r_lvl    <= 1'b0;
            r_id     <= 3'd0;
            r_clr    <= 4'b0;
            r_tmo    <= 4'd0;
            r_ho     <= '0;
            r_isr_hi <= 1'b0;
            r_isr_lo <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_int    <= w_int_nx;
            r_vec    <= w_vec_nx;
            r_lvl    <= w_lvl_nx;
            r_id     <= w_id_nx;
            r_clr    <= w_clr_nx;
            r_tmo    <= w_tmo_nx;
            r_ho     <= w_ho_nx;
            r_isr_hi <= w_isr_hi_nx;
            r_isr_lo <= w_isr_lo_nx;
        end
    end

    assign int_o   = r_int;
    assign int_v   = r_vec;
    assign clr_ie0 = r_clr[0];
    assign clr_tf0 = r_clr[1];
    assign clr_ie1 = r_clr[2];
    assign clr_tf1 = r_clr[3];
    assign isr_hi  = r_isr_hi;
    assign isr_lo  = r_isr_lo;

endmodule
`default_nettype wire

// File: tb/tb_oc8051_int_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oc8051_int_sched
//  Brief    : Directed self-checking bench for oc8051_int_sched.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_oc8051_int_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ie, ip;
    logic       src_ie0, src_tf0, src_ie1, src_tf1, src_ser, src_tf2;
    logic       reti, ack;
    logic       int_o;
    logic [7:0] int_v;
    logic       clr_ie0, clr_tf0, clr_ie1, clr_tf1;
    logic       isr_hi, isr_lo;

    int checks = 0;
    int errors = 0;

    oc8051_int_sched #(.ACK_TIMEOUT(15), .RETI_HOLDOFF(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .ie      (ie),
        .ip      (ip),
        .src_ie0 (src_ie0),
        .src_tf0 (src_tf0),
        .src_ie1 (src_ie1),
        .src_tf1 (src_tf1),
        .src_ser (src_ser),
        .src_tf2 (src_tf2),
        .reti    (reti),
        .ack     (ack),
        .int_o   (int_o),
        .int_v   (int_v),
        .clr_ie0 (clr_ie0),
        .clr_tf0 (clr_tf0),
        .clr_ie1 (clr_ie1),
        .clr_tf1 (clr_tf1),
        .isr_hi  (isr_hi),
        .isr_lo  (isr_lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] clr_vec();
        return {4'b0, clr_tf1, clr_ie1, clr_tf0, clr_ie0};
    endfunction

    initial begin
        rst = 1'b1; ie = 8'h00; ip = 8'h00;
        src_ie0 = 0; src_tf0 = 0; src_ie1 = 0; src_tf1 = 0; src_ser = 0; src_tf2 = 0;
        reti = 0; ack = 0;
        step(); step();
        chk("rst_int_o", {7'b0, int_o}, 8'h00);
        chk("rst_int_v", int_v, 8'h00);
        chk("rst_clr", clr_vec(), 8'h00);
        chk("rst_isr", {6'b0, isr_hi, isr_lo}, 8'h00);
        rst = 1'b0;

        // IE0 beats TF1 at the same level; TF1 waits for RETI plus holdoff.
        ie = 8'h89; ip = 8'h00; src_ie0 = 1; src_tf1 = 1;
        step();
        chk("t1_req", {7'b0, int_o}, 8'h01);
        chk("t1_vec", int_v, 8'h03);
        step();
        chk("t1_pulse_end", {7'b0, int_o}, 8'h00);
        step(); step();
        ack = 1;
        step();
        ack = 0; src_ie0 = 0;
        chk("t1_isr", {6'b0, isr_hi, isr_lo}, 8'h01);
        chk("t1_clr", clr_vec(), 8'h01);
        chk("t1_vec_hold", int_v, 8'h03);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_tf1_blocked", {7'b0, int_o}, 8'h00);
        end
        chk("t1_clr_once", clr_vec(), 8'h00);
        reti = 1;
        step();
        reti = 0;
        chk("t1_reti_isr", {6'b0, isr_hi, isr_lo}, 8'h00);
        chk("t1_ho0", {7'b0, int_o}, 8'h00);
        step();
        chk("t1_ho1", {7'b0, int_o}, 8'h00);
        step();
        chk("t1_ho2", {7'b0, int_o}, 8'h00);
        step();
        chk("t1_tf1_req", {7'b0, int_o}, 8'h01);
        chk("t1_tf1_vec", int_v, 8'h1B);
        step();
        ack = 1;
        step();
        ack = 0; src_tf1 = 0;
        chk("t1_tf1_clr", clr_vec(), 8'h08);
        reti = 1;
        step();
        reti = 0;
        step(); step(); step();
        chk("t1_done_isr", {6'b0, isr_hi, isr_lo}, 8'h00);

        // Nesting: low TF0 in service, high SER nests, high IE1 waits.
        ie = 8'h92; ip = 8'h10; src_tf0 = 1;
        step();
        chk("t2_tf0_vec", int_v, 8'h0B);
        chk("t2_tf0_req", {7'b0, int_o}, 8'h01);
        step();
        ack = 1;
        step();
        ack = 0; src_tf0 = 0;
        chk("t2_lo", {6'b0, isr_hi, isr_lo}, 8'h01);
        chk("t2_clr_tf0", clr_vec(), 8'h02);
        src_ser = 1;
        step();
        chk("t2_ser_req", {7'b0, int_o}, 8'h01);
        chk("t2_ser_vec", int_v, 8'h23);
        step();
        ack = 1;
        step();
        ack = 0; src_ser = 0;
        chk("t2_hi", {6'b0, isr_hi, isr_lo}, 8'h03);
        chk("t2_ser_noclr", clr_vec(), 8'h00);
        ie = 8'h96; ip = 8'h14; src_ie1 = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_ie1_blocked", {7'b0, int_o}, 8'h00);
        end
        reti = 1;
        step();
        reti = 0;
        chk("t2_reti_hi", {6'b0, isr_hi, isr_lo}, 8'h01);
        step(); step();
        chk("t2_ho", {7'b0, int_o}, 8'h00);
        step();
        chk("t2_ie1_req", {7'b0, int_o}, 8'h01);
        chk("t2_ie1_vec", int_v, 8'h13);
        step();
        ack = 1;
        step();
        ack = 0; src_ie1 = 0;
        chk("t2_ie1_clr", clr_vec(), 8'h04);
        chk("t2_hi_again", {6'b0, isr_hi, isr_lo}, 8'h03);
        reti = 1; step(); step(); reti = 0;
        step(); step(); step();
        chk("t2_done_isr", {6'b0, isr_hi, isr_lo}, 8'h00);

        // Priority override, then timeout on the low IE0 request.
        ie = 8'h91; ip = 8'h10; src_ie0 = 1; src_ser = 1;
        step();
        chk("t3_ser_first", int_v, 8'h23);
        step();
        ack = 1;
        step();
        ack = 0; src_ser = 0;
        chk("t3_hi", {6'b0, isr_hi, isr_lo}, 8'h02);
        step();
        chk("t3_ie0_blocked", {7'b0, int_o}, 8'h00);
        reti = 1;
        step();
        reti = 0;
        step();
        chk("t3_ho1", {7'b0, int_o}, 8'h00);
        step();
        chk("t3_ho2", {7'b0, int_o}, 8'h00);
        step();
        chk("t3_ie0_req", {7'b0, int_o}, 8'h01);
        chk("t3_ie0_vec", int_v, 8'h03);
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t4_wait_quiet", {7'b0, int_o}, 8'h00);
        end
        chk("t4_vec_held", int_v, 8'h03);
        chk("t4_no_isr", {6'b0, isr_hi, isr_lo}, 8'h00);
        step();
        chk("t4_rereq", {7'b0, int_o}, 8'h01);
        chk("t4_rereq_vec", int_v, 8'h03);

        // RETI and ACK together: clear first, then set.
        step();
        ack = 1; reti = 1;
        step();
        ack = 0; reti = 0; src_ie0 = 0;
        chk("t5_lo_set", {6'b0, isr_hi, isr_lo}, 8'h01);
        chk("t5_clr_ie0", clr_vec(), 8'h01);
        src_ser = 1;
        step(); step();
        step();
        chk("t5_ser_req", int_v, 8'h23);
        step();
        ack = 1; reti = 1;
        step();
        ack = 0; reti = 0; src_ser = 0;
        chk("t5_lo_cleared_hi_set", {6'b0, isr_hi, isr_lo}, 8'h02);
        reti = 1;
        step();
        reti = 0;
        step(); step(); step();
        ack = 1;
        step();
        ack = 0;
        chk("t5_ack_idle_ignored", {6'b0, isr_hi, isr_lo}, 8'h00);

        // Reset during WAIT (with a coincident ack), enable drop while waiting.
        ie = 8'h81; ip = 8'h00; src_ie0 = 1;
        step();
        chk("t6_req", {7'b0, int_o}, 8'h01);
        step();
        rst = 1; ack = 1;
        step();
        rst = 0; ack = 0;
        chk("t6_rst_vec", int_v, 8'h00);
        chk("t6_rst_clr", clr_vec(), 8'h00);
        chk("t6_rst_isr", {6'b0, isr_hi, isr_lo}, 8'h00);
        step();
        chk("t6_post_clr", clr_vec(), 8'h00);
        chk("t6_post_req", {7'b0, int_o}, 8'h01);
        ack = 1;
        step();
        ack = 0; ie = 8'h00;
        chk("t6_req_ack_ignored", {6'b0, isr_hi, isr_lo}, 8'h00);
        ack = 1;
        step();
        ack = 0; src_ie0 = 0;
        chk("t6_ie_drop_isr", {6'b0, isr_hi, isr_lo}, 8'h01);
        chk("t6_ie_drop_clr", clr_vec(), 8'h01);
        reti = 1;
        step();
        reti = 0;
        step(); step(); step();

        // EA gating, then the optional TF2 source.
        ie = 8'h01; src_ie0 = 1;
        step(); step();
        chk("t7_ea_off", {7'b0, int_o}, 8'h00);
        src_ie0 = 0;
        ie = 8'hA0; ip = 8'h00; src_tf2 = 1;
        step();
`ifdef OC8051_INT_TF2_EN
        chk("t7_tf2_req", {7'b0, int_o}, 8'h01);
        chk("t7_tf2_vec", int_v, 8'h2B);
        step();
        ack = 1;
        step();
        ack = 0; src_tf2 = 0;
        chk("t7_tf2_noclr", clr_vec(), 8'h00);
        chk("t7_tf2_isr", {6'b0, isr_hi, isr_lo}, 8'h01);
`else
        chk("t7_tf2_off", {7'b0, int_o}, 8'h00);
        step();
        chk("t7_tf2_off2", {7'b0, int_o}, 8'h00);
        src_tf2 = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
